nn_layer_sequencer: RTL and testbench
=====================================

# nn_layer_sequencer

Control sequencer for the 15-node feedforward classifier datapath. It takes a start request for one image and steps the shared MAC array through the input layer and three dense layers. Each layer runs as multiply, writeback, then accumulator clear. It drives the weight/result ROM and RAM address, source selects, write enable and clear. After the last layer it reduces the ten output activations to a one-hot classification and reports completion with a start/busy/done handshake.

## Interface
- IN_LEN, 257: input-layer rows (256 pixels plus bias row).
- HID_LEN, 16: rows per hidden/output layer (15 nodes plus bias row).
- NUM_LAYERS, 4: layers sequenced; index 0 is the input layer.
- ADR_LEN, 9: address width; must satisfy 2^ADR_LEN > IN_LEN.
- NUM_OUT, 10: output classes reduced by argmax.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  request to classify the current image; sampled only in IDLE.
- busy  out  1  high from the first MUL cycle through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE state.
- adr  out  ADR_LEN  row address to the weight ROMs, image memory and result RAM.
- layer  out  2  weight-bank select (src2 mux) for the current layer.
- src1_sel  out  1  0 = image pixel, 1 = previous-layer result.
- we  out  1  result RAM write enable.
- clear  out  1  accumulator clear (asynchronous clear in the datapath).
- out_vals  in  NUM_OUT*16  signed Q15 outputs of the final layer; element i is at bits [16*i+15:16*i].
- classification  out  NUM_OUT  one-hot winning class; bit i corresponds to element i.
- class_valid  out  1  classification holds a valid result.

## Operation
- States: IDLE, MUL, WB, CLR, ARGMAX, DONE.
- **IDLE**: clear=1, we=0, adr=0, layer=0, busy=0.
  - start=1 → MUL with layer=0.
  - start=0 → stay in IDLE.
- **MUL**: adr counts 0..LEN-1, one row per cycle, with clear=0. LEN is IN_LEN for layer 0 and HID_LEN otherwise. After the cycle with adr=LEN-1 → WB.
- **WB**: we=1 for exactly one cycle; adr=0 → CLR.
- **CLR**: clear=1 for one cycle.
  - layer<NUM_LAYERS-1 → layer increments, then MUL.
  - Otherwise → ARGMAX.
- **ARGMAX**: index k counts 0..NUM_OUT-1, one element per cycle.
  - The comparison is signed 16-bit. best is updated only when out_vals[k] > best (strict), so ties go to the lowest index.
  - best initialises to out_vals[0] with index 0, so an all-equal or all-zero input selects class 0.
  - After k=NUM_OUT-1 → DONE.
- **DONE**: done=1 for one cycle, classification registered as one-hot of the best index, class_valid=1 → IDLE.
- src1_sel=0 while layer=0 and 1 otherwise.
- classification and class_valid hold until the next accepted start. On that start, class_valid clears in the first MUL cycle.
- start is ignored while busy. It is not queued.
- reset mid-operation: immediate return to IDLE and all outputs go to reset values. No partial writeback occurs after reset.

## Timing
- Reset values: busy=0, done=0, we=0, clear=1, adr=0, layer=0, src1_sel=0, classification=0, class_valid=0.
- Cycle numbering: the edge that samples start is cycle 0.
- Layer 0 (image source):
  - MUL cycles 1..257 (adr 0..256).
  - WB at cycle 258, CLR at cycle 259.
- Layer 1: MUL 260..275, WB 276, CLR 277.
- Layer 2: MUL 278..293, WB 294, CLR 295.
- Layer 3: MUL 296..311, WB 312, CLR 313.
- ARGMAX cycles 314..323; DONE at cycle 324. The block accepts a new start at cycle 325 at the earliest.
- Memories are combinational-read. The accumulator sum is final in the WB cycle, and result RAM contents update on the WB edge.
- out_vals must be stable from CLR of the last layer through ARGMAX.

## Configuration
- NN_ARGMAX_EN defined:
  - The ARGMAX state and comparator are compiled in.
  - Timing is as above.
- NN_ARGMAX_EN undefined:
  - The ARGMAX state is removed; CLR of the last layer goes directly to DONE at cycle 314.
  - classification is tied to 0.
  - class_valid still pulses and holds as specified, signalling only that the layer outputs are ready in out_vals.

## Test plan
- reset, then start pulse at cycle 0 → we high only at cycles 258, 276, 294, 312.
  - src1_sel=0 through cycle 259, then 1.
  - done at cycle 324 with busy=1 over cycles 1..324.
- out_vals = {0,…,0x1200 at index 7,…,0x0800 at index 2} → classification=10'b0010000000 (bit 7) and class_valid=1 after DONE.
- Tie case: indices 3 and 8 both 0x3000 and all others 0 → bit 3 set. All zeros → bit 0 set.
- start held high through a whole run → exactly one run per IDLE visit; the second run begins at cycle 326.
- reset asserted at cycle 270 (layer 1 MUL) → same-cycle IDLE outputs and no we pulse. A fresh start then reproduces the nominal run timing.
- Build without NN_ARGMAX_EN → done at cycle 314 and classification=0 for any out_vals.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Control sequencer for the 15-node feedforward classifier: steps the shared MAC
// array through four layers, then argmax-reduces the outputs. Define NN_ARGMAX_EN
// to compile in the ARGMAX state and comparator; otherwise classification is 0.
module nn_layer_sequencer #(
  parameter int IN_LEN     = 257,
  parameter int HID_LEN    = 16,
  parameter int NUM_LAYERS = 4,
  parameter int ADR_LEN    = 9,
  parameter int NUM_OUT    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADR_LEN-1:0]    adr,
  output logic [1:0]            layer,
  output logic                  src1_sel,
  output logic                  we,
  output logic                  clear,
  input  logic [NUM_OUT*16-1:0] out_vals,
  output logic [NUM_OUT-1:0]    classification,
  output logic                  class_valid
);

`ifdef NN_ARGMAX_EN
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_WB, S_CLR, S_ARGMAX, S_DONE} state_t;
  localparam int KW = $clog2(NUM_OUT);
  logic [KW-1:0] k_q, k_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_WB, S_CLR, S_DONE} state_t;
`endif

  state_t             state_q, state_d;
  logic [ADR_LEN-1:0] adr_q, adr_d;
  logic [1:0]         layer_q, layer_d;
  logic               class_valid_q, class_valid_d;
  logic [ADR_LEN-1:0] last_adr;

  // Layer 0 walks the image plus bias row; later layers walk the hidden rows.
  assign last_adr = (layer_q == 2'd0) ? ADR_LEN'(IN_LEN - 1) : ADR_LEN'(HID_LEN - 1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    adr_d         = adr_q;
    layer_d       = layer_q;
    class_valid_d = class_valid_q;
    unique case (state_q)
      S_IDLE: begin
        adr_d   = '0;
        layer_d = '0;
        if (start) begin
          state_d       = S_MUL;
          class_valid_d = 1'b0;
        end
      end
      S_MUL: begin
        if (adr_q == last_adr) begin
          adr_d   = '0;
          state_d = S_WB;
        end else begin
          adr_d = adr_q + 1'b1;
        end
      end
      S_WB: state_d = S_CLR;
      S_CLR: begin
        if (layer_q != 2'(NUM_LAYERS - 1)) begin
          layer_d = layer_q + 2'd1;
          state_d = S_MUL;
        end else begin
`ifdef NN_ARGMAX_EN
          state_d = S_ARGMAX;
`else
          state_d       = S_DONE;
          class_valid_d = 1'b1;
`endif
        end
      end
`ifdef NN_ARGMAX_EN
      S_ARGMAX: begin
        if (k_q == KW'(NUM_OUT - 1)) begin
          state_d       = S_DONE;
          class_valid_d = 1'b1;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        layer_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      adr_q         <= '0;
      layer_q       <= '0;
      class_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      adr_q         <= adr_d;
      layer_q       <= layer_d;
      class_valid_q <= class_valid_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign we          = (state_q == S_WB);
  assign clear       = (state_q == S_IDLE) || (state_q == S_CLR);
  assign adr         = adr_q;
  assign layer       = layer_q;
  assign src1_sel    = (layer_q != 2'd0);
  assign class_valid = class_valid_q;

`ifdef NN_ARGMAX_EN
  logic signed [15:0] vals [NUM_OUT];
  logic signed [15:0] best_q, best_d;
  logic [KW-1:0]      best_idx_q, best_idx_d;
  logic [NUM_OUT-1:0] class_q, class_d;

  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) vals[i] = out_vals[16*i +: 16];
  end

  // Strict greater-than keeps the lowest index on ties; k=0 seeds best.
  always_comb begin
    k_d        = k_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    if (state_q == S_IDLE && start) class_d = '0;
    if (state_q == S_CLR) k_d = '0;
    if (state_q == S_ARGMAX) begin
      k_d = k_q + 1'b1;
      if (k_q == '0 || vals[k_q] > best_q) begin
        best_d     = vals[k_q];
        best_idx_d = k_q;
      end
      if (k_q == KW'(NUM_OUT - 1)) class_d = NUM_OUT'(1) << best_idx_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
    end else begin
      k_q        <= k_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
    end
  end

  assign classification = class_q;
`else
  logic unused_out_vals;
  assign unused_out_vals = ^out_vals;
  assign classification  = '0;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: cycle-exact control timing, argmax cases,
// held start, and mid-run reset. Honours NN_ARGMAX_EN the same way as the RTL.
module tb_nn_layer_sequencer;
  localparam int ADR_LEN = 9;
  localparam int NUM_OUT = 10;
`ifdef NN_ARGMAX_EN
  localparam int   D         = 324;
  localparam logic ARGMAX_ON = 1'b1;
`else
  localparam int   D         = 314;
  localparam logic ARGMAX_ON = 1'b0;
`endif
  localparam int MAXC = 700;

  typedef struct packed {
    logic busy, done, we, clear, src1;
    logic [1:0] layer;
    logic [ADR_LEN-1:0] adr;
  } obs_t;

  logic                  clk = 1'b0;
  logic                  reset, start;
  logic                  busy, done, src1_sel, we, clear, class_valid;
  logic [ADR_LEN-1:0]    adr;
  logic [1:0]            layer;
  logic [NUM_OUT*16-1:0] out_vals;
  logic [NUM_OUT-1:0]    classification;

  int   tests_run = 0;
  int   tests_failed = 0;
  obs_t obs_a [0:MAXC];
  logic cv_a  [0:MAXC];

  nn_layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .adr(adr), .layer(layer), .src1_sel(src1_sel), .we(we), .clear(clear),
    .out_vals(out_vals), .classification(classification), .class_valid(class_valid)
  );

  always #5 clk = ~clk;

  function automatic obs_t cur_obs();
    return '{busy: busy, done: done, we: we, clear: clear, src1: src1_sel, layer: layer, adr: adr};
  endfunction

  localparam obs_t IDLE_OBS = '{busy: 1'b0, done: 1'b0, we: 1'b0, clear: 1'b1, src1: 1'b0,
                                 layer: 2'd0, adr: '0};

  // Expected outputs c cycles after the start-sampling edge, from the timing table.
  function automatic obs_t exp_obs(int c);
    obs_t e;
    int   s, len;
    e = IDLE_OBS;
    if (c < 1 || c > D) return e;
    e.busy  = 1'b1;
    e.clear = 1'b0;
    e.done  = (c == D);
    e.layer = 2'd3;
    s = 1;
    for (int l = 0; l < 4; l++) begin
      len = (l == 0) ? 257 : 16;
      if (c >= s && c <= s + len + 1) begin
        e.layer = 2'(l);
        if (c < s + len) e.adr = ADR_LEN'(c - s);
        else if (c == s + len) e.we = 1'b1;
        else e.clear = 1'b1;
      end
      s = s + len + 2;
    end
    e.src1 = (e.layer != 2'd0);
    return e;
  endfunction

  task automatic run_cycles(input int n, input bit hold);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      obs_a[c] = cur_obs();
      cv_a[c]  = class_valid;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input int n, input int period);
    obs_t e;
    for (int c = 1; c <= n; c++) begin
      e = (c <= period) ? exp_obs(c) : exp_obs(c - period);
      tests_run++;
      if (obs_a[c] !== e) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs_a[c], e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    out_vals = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cur_obs() !== IDLE_OBS) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected %h", cur_obs(), IDLE_OBS);
    end
    tests_run++;
    if ({classification, class_valid} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_class: got %b/%b expected 0/0", classification, class_valid);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (cur_obs() !== IDLE_OBS) begin
      tests_failed++;
      $display("FAIL idle_without_start: got %h expected %h", cur_obs(), IDLE_OBS);
    end
  endtask

  task automatic test_timing(input string name);
    run_cycles(D + 1, 1'b0);
    check_run(name, D + 1, D + 1);
    tests_run++;
    if (cv_a[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s class_valid first MUL: got %b expected 0", name, cv_a[1]);
    end
    tests_run++;
    if (cv_a[D + 1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s class_valid after DONE: got %b expected 1", name, cv_a[D + 1]);
    end
  endtask

  task automatic test_classify(input string name, input logic [NUM_OUT*16-1:0] vals,
                               input logic [NUM_OUT-1:0] exp_argmax);
    logic [NUM_OUT-1:0] exp_class;
    exp_class = ARGMAX_ON ? exp_argmax : '0;
    out_vals = vals;
    run_cycles(D + 1, 1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (classification !== exp_class || class_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: got class=%b valid=%b expected class=%b valid=1",
               name, classification, class_valid, exp_class);
    end
  endtask

  task automatic test_back_to_back();
    run_cycles(2 * D + 2, 1'b1);
    check_run("held_start", 2 * D + 2, D + 1);
    tests_run++;
    if ({cv_a[1], cv_a[D + 1], cv_a[D + 2], cv_a[2 * D + 2]} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL held_start class_valid: got %b%b%b%b expected 0101",
               cv_a[1], cv_a[D + 1], cv_a[D + 2], cv_a[2 * D + 2]);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (cur_obs() !== IDLE_OBS) begin
      tests_failed++;
      $display("FAIL held_start_no_queue: got %h expected %h", cur_obs(), IDLE_OBS);
    end
  endtask

  task automatic test_reset_midrun();
    int we_seen;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 270; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (cur_obs() !== IDLE_OBS || class_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset_outputs: got %h/%b expected %h/0", cur_obs(), class_valid, IDLE_OBS);
    end
    we_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3) reset = 1'b0;
      if (we || busy) we_seen++;
    end
    tests_run++;
    if (we_seen != 0) begin
      tests_failed++;
      $display("FAIL midrun_reset_quiet: got %0d active cycles expected 0", we_seen);
    end
    test_timing("after_reset_run");
  endtask

  initial begin
    test_reset();
    test_timing("nominal_run");
    test_classify("argmax_bit7", {16'h0, 16'h0, 16'h1200, 16'h0, 16'h0, 16'h0, 16'h0,
                                  16'h0800, 16'h0, 16'h0}, 10'b0010000000);
    test_classify("argmax_tie", {16'h0, 16'h3000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3000,
                                 16'h0, 16'h0, 16'h0}, 10'b0000001000);
    test_classify("argmax_zeros", '0, 10'b0000000001);
    test_classify("argmax_negative", {16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF,
                                      16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000},
                  10'b0000100000);
    test_classify("argmax_last", {16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                                  16'h0, 16'h0, 16'h7FFE}, 10'b1000000000);
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
